// File: rtl/score_bcd.sv
// score_bcd: iterative double-dabble binary-to-BCD converter for the score display.
// One bit per clock, start/busy/done handshake, saturates to 9999.
module score_bcd #(
  parameter int WIDTH  = 14,
  parameter int MAXVAL = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] binary,
  output logic [15:0]      bcd,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAXVAL);
  localparam logic [3:0]       LAST  = 4'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] bin_sh;
  logic [15:0]      scr;
  logic [15:0]      adj;
  logic [3:0]       cnt;
  logic             ovr;
  logic [15:0]      res;
  logic             res_ovf;
  logic             fin;

  always_comb begin
    adj = scr;
    for (int i = 0; i < 4; i++) begin
      if (scr[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bin_sh   <= '0;
      scr      <= '0;
      cnt      <= '0;
      ovr      <= 1'b0;
      res      <= '0;
      res_ovf  <= 1'b0;
      fin      <= 1'b0;
      bcd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      // Result is staged one cycle so bcd and done publish together.
      done <= fin;
      fin  <= 1'b0;
      if (fin) begin
        bcd      <= res;
        overflow <= res_ovf;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_sh <= binary;
            scr    <= '0;
            ovr    <= (binary > MAX_W);
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          scr    <= {adj[14:0], bin_sh[WIDTH-1]};
          bin_sh <= {bin_sh[WIDTH-2:0], 1'b0};
          cnt    <= cnt + 4'd1;
          if (cnt == LAST)
            state <= FINISH;
        end
        FINISH: begin
          res     <= ovr ? 16'h9999 : scr;
          res_ovf <= ovr;
          fin     <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
